// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU dispatcher: op codes, flag bit positions,
// FSM state encoding and op-class decode helpers.
package alu_dispatch_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD    = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 6'd1;
  localparam logic [OP_W-1:0] OP_AND    = 6'd2;
  localparam logic [OP_W-1:0] OP_OR     = 6'd3;
  localparam logic [OP_W-1:0] OP_XOR    = 6'd4;
  localparam logic [OP_W-1:0] OP_NOR    = 6'd5;
  localparam logic [OP_W-1:0] OP_SLT    = 6'd6;
  localparam logic [OP_W-1:0] OP_MULT   = 6'd7;
  localparam logic [OP_W-1:0] OP_DIV    = 6'd8;
  localparam logic [OP_W-1:0] OP_REMDER = 6'd9;

  // Flag vector layout is {Zero, Overflow, CarryOut, Negative}
  localparam int unsigned FLAG_ZERO  = 3;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_NEG   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_REMDER);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REMDER);
  endfunction

endpackage

// File: rtl/alu_dispatch.sv
// Single-entry dispatcher: accepts one request, issues it to an external ALU,
// waits for completion (padded for mul/div), then holds the response until taken.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned OPW         = 6,
  parameter int unsigned TAGW        = 4,
  parameter int unsigned MULDIV_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  input  logic [OPW-1:0]    req_op,
  input  logic [TAGW-1:0]   req_tag,
  output logic              alu_valid,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [OPW-1:0]    alu_op,
  input  logic              alu_ready,
  input  logic              alu_done,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [TAGW-1:0]   rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned CNTW = (MULDIV_WAIT > 0) ? $clog2(MULDIV_WAIT + 1) : 1;

  state_e              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [OPW-1:0]      op_q, op_d;
  logic [TAGW-1:0]     tag_q, tag_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [TAGW-1:0]     rtag_q, rtag_d;
  logic                err_q, err_d;
  logic                req_ready_q, busy_q, alu_valid_q, rsp_valid_q;

  // Next-state, operand latch and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    res_d   = res_q;
    flags_d = flags_q;
    rtag_d  = rtag_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          tag_d   = req_tag;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (alu_ready) begin
          cnt_d   = is_muldiv(OP_W'(op_q)) ? CNTW'(MULDIV_WAIT) : '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else if (alu_done) begin
          res_d   = alu_result;
          flags_d = alu_flags;
          rtag_d  = tag_q;
          err_d   = is_div(OP_W'(op_q)) && (b_q == '0);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Operands return to zero so the ALU bus is quiet while idle
        if (rsp_ready) begin
          a_d     = '0;
          b_d     = '0;
          op_d    = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      rtag_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      alu_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      rtag_q      <= rtag_d;
      err_q       <= err_d;
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      alu_valid_q <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
      rsp_valid_q <= (state_d == ST_HOLD);
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign alu_valid  = alu_valid_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_tag    = rtag_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a behavioural ALU responder plus directed and random
// transactions checked against arithmetic expectations.
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 6;
  localparam int unsigned TAGW  = 4;
  localparam int unsigned MDW   = 4;

  logic             clk, rst_n;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_a, req_b;
  logic [OPW-1:0]   req_op;
  logic [TAGW-1:0]  req_tag;
  logic             alu_valid, alu_ready, alu_done;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [OPW-1:0]   alu_op;
  logic [3:0]       alu_flags;
  logic             rsp_valid, rsp_ready, rsp_err, busy;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic [TAGW-1:0]  rsp_tag;

  int n_tests = 0;
  int n_fail  = 0;
  int alu_lat = 0;
  int alu_cnt;
  bit alu_acc;

  alu_dispatch #(.WIDTH(WIDTH), .OPW(OPW), .TAGW(TAGW), .MULDIV_WAIT(MDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_tag(req_tag),
    .alu_valid(alu_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_ready(alu_ready), .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU arithmetic
  function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_NOR:    return ~(a | b);
      OP_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_MULT:   return a * b;
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMDER: return (b == 0) ? 32'hFFFF_FFFF : a % b;
      default:   return a ^ b ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [32:0] w;
    logic [3:0]  f;
    r = ref_result(op, a, b);
    f = '0;
    f[FLAG_ZERO] = (r == 0);
    f[FLAG_NEG]  = r[31];
    if (op == OP_ADD) begin
      w = {1'b0, a} + {1'b0, b};
      f[FLAG_CARRY] = w[32];
      f[FLAG_OVF]   = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (op == OP_SUB) begin
      w = {1'b0, a} - {1'b0, b};
      f[FLAG_CARRY] = w[32];
      f[FLAG_OVF]   = (a[31] != b[31]) && (r[31] != a[31]);
    end
    return f;
  endfunction

  assign alu_result = ref_result(alu_op, alu_a, alu_b);
  assign alu_flags  = ref_flags(alu_op, alu_a, alu_b);

  // ALU responder: accepts on valid&&ready, signals done alu_lat cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_acc <= 1'b0; alu_done <= 1'b0; alu_cnt <= 0;
    end else if (!alu_valid) begin
      alu_acc <= 1'b0; alu_done <= 1'b0;
    end else if (!alu_acc) begin
      if (alu_ready) begin
        alu_acc <= 1'b1; alu_done <= (alu_lat == 0); alu_cnt <= alu_lat;
      end
    end else if (!alu_done) begin
      if (alu_cnt <= 1) alu_done <= 1'b1;
      alu_cnt <= alu_cnt - 1;
    end
  end

  // Drive one request; lat counts cycles from the handshake cycle (0) to the first rsp_valid cycle
  task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input bit rnd, output int lat,
                         output logic [31:0] res, output logic [3:0] fl, output logic [3:0] tg,
                         output logic er, output bit stable, output bit timeout);
    int guard;
    logic [40:0] first;
    stable = 1'b1; timeout = 1'b0; lat = 0; res = '0; fl = '0; tg = '0; er = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!req_ready) begin timeout = 1'b1; return; end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    alu_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    do begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (alu_valid && (alu_a !== a || alu_b !== b || alu_op !== op)) stable = 1'b0;
      if (rnd) begin
        alu_ready = 1'($urandom_range(0, 1));
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end while (!rsp_valid && lat < 200);
    if (!rsp_valid) begin timeout = 1'b1; return; end
    res = rsp_result; fl = rsp_flags; tg = rsp_tag; er = rsp_err;
    first = {rsp_valid, rsp_result, rsp_flags, rsp_err};
    guard = 0;
    while (!rsp_ready) begin
      @(negedge clk);
      guard++;
      if ({rsp_valid, rsp_result, rsp_flags, rsp_err} !== first || rsp_tag !== tg || req_ready !== 1'b0)
        stable = 1'b0;
      rsp_ready = (guard > 40) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset;
    int guard;
    #12;
    n_tests++;
    if ({req_ready, busy, alu_valid, rsp_valid, rsp_err} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 10000", {req_ready, busy, alu_valid, rsp_valid, rsp_err});
    end
    n_tests++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== '0 || rsp_result !== '0 || rsp_flags !== '0 || rsp_tag !== '0) begin
      n_fail++; $display("FAIL reset_data got a=%h b=%h op=%h res=%h fl=%b tag=%h want all zero",
                         alu_a, alu_b, alu_op, rsp_result, rsp_flags, rsp_tag);
    end
    req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd1; req_b = 32'd2; req_tag = 4'd1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if ({busy, req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL first_accept got busy,ready=%b want 10", {busy, req_ready});
    end
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd3 || rsp_tag !== 4'd1) begin
      n_fail++; $display("FAIL first_result got v=%b res=%0d tag=%0d want 1 3 1", rsp_valid, rsp_result, rsp_tag);
    end
  endtask

  task automatic test_add;
    int lat; logic [31:0] res; logic [3:0] fl, tg; logic er; bit st, to;
    run_txn(OP_ADD, 32'd5, 32'd7, 4'd3, 1'b0, lat, res, fl, tg, er, st, to);
    n_tests++;
    if (lat !== 3 || to) begin n_fail++; $display("FAIL add_latency got %0d (timeout=%0d) want 3", lat, to); end
    n_tests++;
    if (res !== 32'd12 || fl !== 4'b0000 || tg !== 4'd3 || er !== 1'b0) begin
      n_fail++; $display("FAIL add_rsp got res=%0d fl=%b tag=%0d err=%b want 12 0000 3 0", res, fl, tg, er);
    end
  endtask

  task automatic test_sub_zero;
    int lat; logic [31:0] res; logic [3:0] fl, tg; logic er; bit st, to;
    run_txn(OP_SUB, 32'd5, 32'd5, 4'd9, 1'b0, lat, res, fl, tg, er, st, to);
    n_tests++;
    if (res !== 32'd0 || fl[FLAG_ZERO] !== 1'b1 || fl[FLAG_NEG] !== 1'b0 || tg !== 4'd9 || to) begin
      n_fail++; $display("FAIL sub_zero got res=%0d fl=%b tag=%0d want 0 Z=1 N=0 tag 9", res, fl, tg);
    end
  endtask

  task automatic test_mult;
    int lat; logic [31:0] res; logic [3:0] fl, tg; logic er; bit st, to;
    run_txn(OP_MULT, 32'd6, 32'd7, 4'd4, 1'b0, lat, res, fl, tg, er, st, to);
    n_tests++;
    if (lat !== 3 + MDW || to) begin n_fail++; $display("FAIL mult_latency got %0d want %0d", lat, 3 + MDW); end
    n_tests++;
    if (res !== 32'd42 || er !== 1'b0 || tg !== 4'd4) begin
      n_fail++; $display("FAIL mult_rsp got res=%0d err=%b tag=%0d want 42 0 4", res, er, tg);
    end
    n_tests++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL mult_operand_stable got %b want 1", st); end
  endtask

  task automatic test_div;
    int lat; logic [31:0] res; logic [3:0] fl, tg; logic er; bit st, to;
    run_txn(OP_DIV, 32'd10, 32'd0, 4'd2, 1'b0, lat, res, fl, tg, er, st, to);
    n_tests++;
    if (res !== 32'hFFFF_FFFF || er !== 1'b1 || to) begin
      n_fail++; $display("FAIL div_zero got res=%h err=%b want ffffffff 1", res, er);
    end
    run_txn(OP_REMDER, 32'd9, 32'd0, 4'd7, 1'b0, lat, res, fl, tg, er, st, to);
    n_tests++;
    if (res !== 32'hFFFF_FFFF || er !== 1'b1 || tg !== 4'd7 || to) begin
      n_fail++; $display("FAIL rem_zero got res=%h err=%b tag=%0d want ffffffff 1 7", res, er, tg);
    end
    run_txn(OP_DIV, 32'd10, 32'd3, 4'd8, 1'b0, lat, res, fl, tg, er, st, to);
    n_tests++;
    if (res !== 32'd3 || er !== 1'b0 || lat !== 3 + MDW) begin
      n_fail++; $display("FAIL div_normal got res=%0d err=%b lat=%0d want 3 0 %0d", res, er, lat, 3 + MDW);
    end
  endtask

  task automatic test_unknown_op;
    int lat; logic [31:0] res, a, b; logic [3:0] fl, tg; logic er; bit st, to;
    a = $urandom; b = 32'd0;
    run_txn(6'h3F, a, b, 4'd11, 1'b0, lat, res, fl, tg, er, st, to);
    n_tests++;
    if (res !== ref_result(6'h3F, a, b) || er !== 1'b0 || lat !== 3 || to) begin
      n_fail++; $display("FAIL unknown_op got res=%h err=%b lat=%0d want %h 0 3", res, er, lat, ref_result(6'h3F, a, b));
    end
  endtask

  task automatic test_back_to_back;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd1; req_b = 32'd2; req_tag = 4'd5;
    rsp_ready = 1'b0; alu_ready = 1'b1;
    @(negedge clk);
    req_a = 32'd10; req_b = 32'd20; req_tag = 4'd6;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({rsp_valid, req_ready} !== 2'b10 || rsp_result !== 32'd3 || rsp_tag !== 4'd5) begin
        n_fail++; $display("FAIL hold_stable cyc%0d got v=%b ready=%b res=%0d tag=%0d want 1 0 3 5",
                           i, rsp_valid, req_ready, rsp_result, rsp_tag);
      end
      if (i < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL drain got v,ready=%b want 01", {rsp_valid, req_ready});
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if ({busy, req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL second_accept got busy,ready=%b want 10", {busy, req_ready});
    end
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd30 || rsp_tag !== 4'd6) begin
      n_fail++; $display("FAIL second_rsp got v=%b res=%0d tag=%0d want 1 30 6", rsp_valid, rsp_result, rsp_tag);
    end
  endtask

  task automatic test_reset_mid;
    int guard; bit seen;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd4; req_tag = 4'd12;
    rsp_ready = 1'b1; alu_ready = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if ({busy, alu_valid, rsp_valid} !== 3'b110) begin
      n_fail++; $display("FAIL pre_reset_wait got busy,alu_v,rsp_v=%b want 110", {busy, alu_valid, rsp_valid});
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, busy, alu_valid, rsp_valid, rsp_err} !== 5'b10000 || alu_a !== '0 || alu_b !== '0 || alu_op !== '0) begin
      n_fail++; $display("FAIL async_reset got ctrl=%b a=%h b=%h op=%h want 10000 0 0 0",
                         {req_ready, busy, alu_valid, rsp_valid, rsp_err}, alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    n_tests++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL discard_after_reset got rsp_seen=%b busy=%b want 0 0", seen, busy);
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] res, a, b; logic [3:0] fl, tg, tag; logic [5:0] op; logic er, exp_err; bit st, to;
    for (int n = 0; n < 60; n++) begin
      op  = 6'($urandom_range(0, 15));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      tag = 4'($urandom);
      alu_lat = $urandom_range(0, 3);
      exp_err = ((op == OP_DIV) || (op == OP_REMDER)) && (b == 0);
      run_txn(op, a, b, tag, 1'b1, lat, res, fl, tg, er, st, to);
      n_tests++;
      if (to || res !== ref_result(op, a, b) || fl !== ref_flags(op, a, b) || tg !== tag || er !== exp_err || st !== 1'b1) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got res=%h fl=%b tag=%0d err=%b stable=%b to=%b want %h %b %0d %b 1 0",
                 n, op, a, b, res, fl, tg, er, st, to, ref_result(op, a, b), ref_flags(op, a, b), tag, exp_err);
      end
    end
    alu_lat = 0; alu_ready = 1'b1; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    alu_ready = 1'b1; rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_sub_zero();
    test_mult();
    test_div();
    test_unknown_op();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
